wide_queue: RTL and testbench
=============================

// Module: wide_queue
// PURPOSE
//  Multi-lane, in-order FIFO: accepts up to ENQ_WIDTH entries and delivers up to DEQ_WIDTH per cycle.
//  Any DEPTH is supported (not just powers of 2), and all DEPTH slots are usable.
//  Optional fallthrough/pipe modes. Sits between superscalar fetch/decode/issue stages.
//  Replaces single-lane queues where bandwidth > 1 entry/cycle is needed.
// PARAMETERS
//  Data        gpreg  entry payload type
//  DEPTH       8      storage entries; must be >= max(ENQ_WIDTH, DEQ_WIDTH); need not be 2^n
//  ENQ_WIDTH   2      enqueue lanes
//  DEQ_WIDTH   2      dequeue lanes
//  FALLTHROUGH 0      1: offered enq lanes are visible on deq in the same cycle, behind stored entries
//  PIPE        0      1: enq free space includes slots vacated by same-cycle dequeue
// PORTS
//  clk        in   1                 clock, all state on posedge
//  rst        in   1                 asynchronous reset, active-high
//  flush      in   1                 synchronous clear; priority over enq/deq
//  enq_valid  in   ENQ_WIDTH         lane-valid; producer drives a contiguous prefix from lane 0
//  enq_data   in   Data[ENQ_WIDTH]   lane payloads; lane 0 is oldest
//  enq_ready  out  ENQ_WIDTH         lane i ready iff free > i (prefix mask)
//  deq_valid  out  DEQ_WIDTH         lane j valid iff avail > j (prefix mask)
//  deq_data   out  Data[DEQ_WIDTH]   lane j = j-th oldest available entry
//  deq_ready  in   DEQ_WIDTH         consumer lane-ready
//  count      out  $clog2(DEPTH+1)   stored entries (registered)
//  empty      out  1                 count == 0
//  full       out  1                 count == DEPTH
// BEHAVIOUR
//  - State: head and tail indices in [0, DEPTH-1], plus count in [0, DEPTH].
//    Index add wraps explicitly: (x+k >= DEPTH) ? x+k-DEPTH : x+k. Never rely on bit truncation.
//  - Reset (async): head = tail = count = 0.
//    -> empty = 1, full = 0, enq_ready = all 1s.
//    -> deq_valid = 0 (FALLTHROUGH=1: deq_valid follows enq_valid).
//  - Logical queue = stored entries (oldest at head), followed by enq lanes when FALLTHROUGH=1.
//    avail = count + (FALLTHROUGH ? popcount(enq_valid) : 0), capped at DEQ_WIDTH for display.
//  - Dequeue:
//    D = length of the leading run of lanes j with deq_valid[j] && deq_ready[j].
//    Lanes after the first non-firing lane do not fire even if valid && ready.
//  - Enqueue:
//    free = DEPTH - count + (PIPE ? D : 0).
//    A = min(popcount(enq_valid), free). Lanes 0..A-1 fire.
//  - Per non-flush cycle:
//    lane i < A writes slot (tail+i) mod DEPTH; tail += A; head += D; count += A - D.
//    Bypassed (fallthrough) entries are written too; their slot is already freed by head, so this is harmless.
//  - Latency:
//    FALLTHROUGH=0: 1 cycle enq -> deq_valid.
//    FALLTHROUGH=1: 0 cycles.
//    Registered count/empty/full update the cycle after the fire.
//  - Paths:
//    PIPE makes enq_ready combinational on deq_ready.
//    FALLTHROUGH makes deq_* combinational on enq_*.
//    No loop exists, provided enq_valid does not depend on enq_ready (decoupled rule).
//  - Flush:
//    During flush, enq_ready = 0 and deq_valid = 0, so no handshake occurs.
//    Next cycle: head = tail = count = 0. Storage contents are don't-care.
//  - Simultaneous enq+deq when full: accepted only if PIPE=1 (A <= D); else enq_ready = 0.
//  - Reset asserted mid-operation: state clears immediately; in-flight data is lost, no partial writes matter.
//  - Invalid producer/consumer masks (non-prefix enq_valid) are illegal.
//    Bench asserts on them; RTL behaviour is undefined.
// TESTING (DEPTH=6, ENQ_WIDTH=2, DEQ_WIDTH=3 unless stated)
//  1. Reset mid-burst: rst high with count=4 -> count=0, empty=1, deq_valid=000, enq_ready=11, same cycle.
//  2. Fill with enq_valid=11 for 3 cycles (A..F), deq_ready=0:
//     -> count 2,4,6; full=1; enq_ready=00. All 6 slots are used.
//  3. Wrap-around: repeat 2x enq 2 / deq 3 per cycle across 5 cycles.
//     -> deq order is exactly enq order, with head/tail wrapping through index 5 -> 0.
//  4. Partial-ready dequeue: count=3, deq_ready=101 -> only lane 0 fires, D=1, count=2.
//  5. PIPE=1 at full, deq_ready=011, enq_valid=11 -> A=2, D=2, count stays 6.
//     With PIPE=0, same stimulus -> A=0, count=4.
//  6. FALLTHROUGH=1, empty, enq X,Y, deq_ready=111:
//     -> deq_valid=011, deq_data={-,Y,X} same cycle; count stays 0.
//     With flush high in the same cycle -> no fire.

Source files
------------

// File: rtl/wide_queue.sv
`default_nettype none
// ============================================================================
// Module   : wide_queue
// Purpose  : Multi-lane in-order FIFO. Accepts up to ENQ_WIDTH entries and
//            delivers up to DEQ_WIDTH entries per cycle. Any DEPTH is allowed
//            and every slot is usable. Optional fallthrough (enq lanes
//            visible on deq in the same cycle) and pipe (enq space counts
//            slots freed by a same-cycle dequeue) modes.
// Revision : 1.0 - initial release
// ============================================================================
module wide_queue #(
  parameter type Data        = logic [31:0],
  parameter int  DEPTH       = 8,
  parameter int  ENQ_WIDTH   = 2,
  parameter int  DEQ_WIDTH   = 2,
  parameter bit  FALLTHROUGH = 1'b0,
  parameter bit  PIPE        = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [ENQ_WIDTH-1:0]       enq_valid,
  input  Data                        enq_data [ENQ_WIDTH],
  output logic [ENQ_WIDTH-1:0]       enq_ready,
  output logic [DEQ_WIDTH-1:0]       deq_valid,
  output Data                        deq_data [DEQ_WIDTH],
  input  logic [DEQ_WIDTH-1:0]       deq_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int c_CNT_W     = $clog2(DEPTH + 1);
  localparam int c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_ENQ_IDX_W = (ENQ_WIDTH > 1) ? $clog2(ENQ_WIDTH) : 1;

  Data                r_mem [DEPTH];
  logic [c_IDX_W-1:0] r_head;
  logic [c_IDX_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;

  int   w_n_enq;   // offered enqueue lanes
  int   w_avail;   // entries visible to the consumer
  int   w_n_deq;   // dequeue lanes firing (leading run)
  int   w_free;    // slots the producer may fill this cycle
  int   w_n_acc;   // enqueue lanes firing
  logic w_run;

  // Index add with explicit wrap so non power-of-two depths work; x+k never
  // reaches 2*DEPTH because k is at most DEPTH.
  function automatic logic [c_IDX_W-1:0] idx_add(input logic [c_IDX_W-1:0] x, input int k);
    int s;
    s = int'(x) + k;
    return (s >= DEPTH) ? c_IDX_W'(s - DEPTH) : c_IDX_W'(s);
  endfunction

  // Handshake bookkeeping: visible entries, dequeue run, free space, accepts.
  always_comb begin
    deq_valid = '0;
    enq_ready = '0;
    w_n_enq   = 0;
    for (int i = 0; i < ENQ_WIDTH; i++) w_n_enq = w_n_enq + int'(enq_valid[i]);
    w_avail = int'(r_count) + (FALLTHROUGH ? w_n_enq : 0);
    for (int j = 0; j < DEQ_WIDTH; j++) deq_valid[j] = !flush && (w_avail > j);
    // Only the unbroken run of firing lanes from lane 0 counts.
    w_n_deq = 0;
    w_run   = 1'b1;
    for (int j = 0; j < DEQ_WIDTH; j++) begin
      if (w_run && deq_valid[j] && deq_ready[j]) w_n_deq = w_n_deq + 1;
      else                                       w_run   = 1'b0;
    end
    w_free = DEPTH - int'(r_count) + (PIPE ? w_n_deq : 0);
    for (int i = 0; i < ENQ_WIDTH; i++) enq_ready[i] = !flush && (w_free > i);
    w_n_acc = flush ? 0 : ((w_n_enq < w_free) ? w_n_enq : w_free);
  end

  // Dequeue lanes: stored entries first, then offered enq lanes in fallthrough mode.
  always_comb begin
    for (int j = 0; j < DEQ_WIDTH; j++) begin
      deq_data[j] = r_mem[idx_add(r_head, j)];
      if (FALLTHROUGH && (j >= int'(r_count)) && (j - int'(r_count) < ENQ_WIDTH))
        deq_data[j] = enq_data[c_ENQ_IDX_W'(j - int'(r_count))];
    end
  end

  // Storage write; bypassed entries land in slots already released by head.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_WIDTH; i++)
      if (i < w_n_acc) r_mem[idx_add(r_tail, i)] <= enq_data[i];
  end

  // Pointer and occupancy update; flush returns to the reset state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= idx_add(r_head, w_n_deq);
      r_tail  <= idx_add(r_tail, w_n_acc);
      r_count <= c_CNT_W'(int'(r_count) + w_n_acc - w_n_deq);
    end
  end

  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (int'(r_count) == DEPTH);

endmodule
`default_nettype wire

// File: tb/tb_wide_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wide_queue
// Purpose  : Scoreboard bench for wide_queue. Three instances (plain, PIPE,
//            FALLTHROUGH) share one stimulus stream; a queue-based reference
//            model predicts per-cycle flags and accepted data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wide_queue;

  localparam int DEPTH = 6;

  typedef struct packed {
    logic [1:0] er;
    logic [2:0] dv;
    logic [2:0] cnt;
  } flags_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  enq_valid;
  logic [31:0] enq_data [2];
  logic [2:0]  deq_ready;

  logic [1:0]  enq_ready_w [3];
  logic [2:0]  deq_valid_w [3];
  logic [31:0] deq_data_w  [3][3];
  logic [2:0]  count_w     [3];
  logic        empty_w     [3];
  logic        full_w      [3];

  // Reference model: st = logical stored contents, ex = scoreboard of
  // accepted entries awaiting dequeue, fq = expected per-cycle flags.
  logic [31:0] st [3][$];
  logic [31:0] ex [3][$];
  flags_t      fq [3][$];

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  // cfg0: plain, cfg1: PIPE, cfg2: FALLTHROUGH
  for (genvar g = 0; g < 3; g++) begin : g_dut
    wide_queue #(
      .Data(logic [31:0]), .DEPTH(DEPTH), .ENQ_WIDTH(2), .DEQ_WIDTH(3),
      .FALLTHROUGH(g == 2), .PIPE(g == 1)
    ) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready_w[g]),
      .deq_valid(deq_valid_w[g]), .deq_data(deq_data_w[g]), .deq_ready(deq_ready),
      .count(count_w[g]), .empty(empty_w[g]), .full(full_w[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input int c, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s cfg%0d: got %0h expected %0h at %0t", name, c, got, expv, $time);
    end
  endtask

  // Predict this cycle's outputs for each configuration and advance the model.
  task automatic model_step();
    for (int c = 0; c < 3; c++) begin
      bit     ft, pp, run;
      int     cnt, n, avail, d, fr, a;
      flags_t f;
      ft    = (c == 2);
      pp    = (c == 1);
      cnt   = st[c].size();
      n     = int'(enq_valid[0]) + int'(enq_valid[1]);
      f.cnt = 3'(cnt);
      f.dv  = '0;
      f.er  = '0;
      d     = 0;
      a     = 0;
      if (!flush) begin
        avail = cnt + (ft ? n : 0);
        for (int j = 0; j < 3; j++) f.dv[j] = (avail > j);
        run = 1'b1;
        for (int j = 0; j < 3; j++) begin
          if (run && f.dv[j] && deq_ready[j]) d++;
          else run = 1'b0;
        end
        fr = DEPTH - cnt + (pp ? d : 0);
        for (int i = 0; i < 2; i++) f.er[i] = (fr > i);
        a = (n < fr) ? n : fr;
      end
      fq[c].push_back(f);
      if (flush) begin
        st[c].delete();
        ex[c].delete();
      end else begin
        for (int i = 0; i < a; i++) begin
          st[c].push_back(enq_data[i]);
          ex[c].push_back(enq_data[i]);
        end
        for (int k = 0; k < d; k++) void'(st[c].pop_front());
      end
    end
  endtask

  task automatic drive(input logic [1:0] ev, input logic [2:0] dr, input logic fl,
                       input logic [31:0] d0, input logic [31:0] d1);
    enq_valid   = ev;
    deq_ready   = dr;
    flush       = fl;
    enq_data[0] = d0;
    enq_data[1] = d1;
    model_step();
  endtask

  task automatic step(input logic [1:0] ev, input logic [2:0] dr, input logic fl);
    drive(ev, dr, fl, $urandom, $urandom);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare flags, visible data, and retire fired entries.
  always @(negedge clk) begin
    if (mon_en) begin
      assert (enq_valid != 2'b10) else $error("non-prefix enq_valid driven");
      for (int c = 0; c < 3; c++) begin
        flags_t f;
        int     nd;
        bit     run;
        chk("expect_queued", c, 64'(fq[c].size() > 0), 64'd1);
        if (fq[c].size() > 0) begin
          f = fq[c].pop_front();
          chk("enq_ready", c, enq_ready_w[c], f.er);
          chk("deq_valid", c, deq_valid_w[c], f.dv);
          chk("count",     c, count_w[c],     f.cnt);
          chk("empty",     c, empty_w[c],     64'(f.cnt == 0));
          chk("full",      c, full_w[c],      64'(f.cnt == DEPTH));
          for (int j = 0; j < 3; j++)
            if (f.dv[j] && j < ex[c].size()) chk("deq_data", c, deq_data_w[c][j], ex[c][j]);
          nd  = 0;
          run = 1'b1;
          for (int j = 0; j < 3; j++) begin
            if (run && deq_valid_w[c][j] && deq_ready[j]) nd++;
            else run = 1'b0;
          end
          for (int k = 0; k < nd; k++) begin
            if (ex[c].size() > 0) void'(ex[c].pop_front());
            else chk("deq_underflow", c, 64'd1, 64'd0);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] x, y;
    logic [1:0]  ev;
    rst = 1'b1; flush = 1'b0; enq_valid = '0; deq_ready = '0;
    enq_data[0] = '0; enq_data[1] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("rst_count", c, count_w[c], 0);
      chk("rst_empty", c, empty_w[c], 1);
      chk("rst_full", c, full_w[c], 0);
      chk("rst_enq_ready", c, enq_ready_w[c], 2'b11);
      chk("rst_deq_valid", c, deq_valid_w[c], 3'b000);
    end
    mon_en = 1'b1;

    // Reset in the middle of a burst
    step(2'b11, 3'b000, 1'b0);
    step(2'b11, 3'b000, 1'b0);
    for (int c = 0; c < 3; c++) chk("burst_count", c, count_w[c], 4);
    mon_en = 1'b0;
    enq_valid = '0; deq_ready = '0;
    #1 rst = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("midrst_count", c, count_w[c], 0);
      chk("midrst_empty", c, empty_w[c], 1);
      chk("midrst_deq_valid", c, deq_valid_w[c], 3'b000);
      chk("midrst_enq_ready", c, enq_ready_w[c], 2'b11);
      st[c].delete(); ex[c].delete(); fq[c].delete();
    end
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Fill all six slots
    for (int k = 1; k <= 3; k++) begin
      step(2'b11, 3'b000, 1'b0);
      chk("fill_count", 0, count_w[0], 2 * k);
    end
    for (int c = 0; c < 3; c++) begin
      chk("fill_full", c, full_w[c], 1);
      chk("fill_enq_ready", c, enq_ready_w[c], 2'b00);
    end

    // Wrap-around streaming
    step(2'b00, 3'b000, 1'b1);
    repeat (10) step(2'b11, 3'b111, 1'b0);

    // Partial-ready dequeue
    step(2'b00, 3'b000, 1'b1);
    step(2'b11, 3'b000, 1'b0);
    step(2'b01, 3'b000, 1'b0);
    chk("partial_pre_count", 0, count_w[0], 3);
    step(2'b00, 3'b101, 1'b0);
    for (int c = 0; c < 3; c++) chk("partial_count", c, count_w[c], 2);

    // Simultaneous enq+deq at full
    step(2'b00, 3'b000, 1'b1);
    repeat (3) step(2'b11, 3'b000, 1'b0);
    drive(2'b11, 3'b011, 1'b0, $urandom, $urandom);
    #1;
    chk("pipe_enq_ready", 1, enq_ready_w[1], 2'b11);
    chk("nopipe_enq_ready", 0, enq_ready_w[0], 2'b00);
    @(posedge clk);
    #1;
    chk("pipe_count", 1, count_w[1], 6);
    chk("nopipe_count", 0, count_w[0], 4);

    // Fallthrough from empty, then the same with flush
    step(2'b00, 3'b000, 1'b1);
    x = $urandom; y = $urandom;
    drive(2'b11, 3'b111, 1'b0, x, y);
    #1;
    chk("ft_deq_valid", 2, deq_valid_w[2], 3'b011);
    chk("ft_lane0", 2, deq_data_w[2][0], x);
    chk("ft_lane1", 2, deq_data_w[2][1], y);
    @(posedge clk);
    #1;
    chk("ft_count", 2, count_w[2], 0);
    drive(2'b11, 3'b111, 1'b1, $urandom, $urandom);
    #1;
    chk("ft_flush_deq_valid", 2, deq_valid_w[2], 3'b000);
    chk("ft_flush_enq_ready", 2, enq_ready_w[2], 2'b00);
    @(posedge clk);
    #1;
    chk("ft_flush_count", 2, count_w[2], 0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 2))
        0:       ev = 2'b00;
        1:       ev = 2'b01;
        default: ev = 2'b11;
      endcase
      step(ev, 3'($urandom), ($urandom_range(0, 31) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
